// File: rtl/arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   arb_state_t : grant FSM states
//   arb_owner_t : which requester owns the bus command
//   pick_owner  : LS-first arbitration with IF anti-starvation override
package arb_pkg;

  localparam int unsigned LS_STREAK_MAX_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_IF,
    ST_REQ_LS,
    ST_WAIT_IF,
    ST_WAIT_LS
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } arb_owner_t;

  // LS is the older instruction and wins unless IF has been starved long enough.
  function automatic arb_owner_t pick_owner(input logic ls_req,
                                            input logic if_req,
                                            input logic streak_at_max);
    return (ls_req && !(if_req && streak_at_max)) ? OWN_LS : OWN_IF;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst : clock, synchronous active-high reset
//   inc      : count up by one unless already at MAX
//   clr      : return to zero (wins over inc)
//   cnt      : registered count
module sat_counter #(
  parameter int unsigned  W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch (IF) and
// load/store (LS). One outstanding transaction; LS has priority, a streak
// counter bounds IF starvation, and IF flush drops stale fetch data.
//   clk, rst            : clock, synchronous active-high reset
//   if_req/if_addr      : fetch request (held until if_gnt)
//   if_flush            : branch/jump redirect, kills pending fetch
//   if_gnt/if_rvalid    : fetch accepted / fetch data valid pulses
//   if_rdata            : fetch data (mem_rdata pass-through, else 0)
//   ls_req/we/addr/wdata/be : load/store request (held until ls_gnt)
//   ls_gnt/ls_rvalid    : accepted / load data or store ack pulses
//   ls_rdata            : load data (mem_rdata pass-through, else 0)
//   mem_req/we/addr/wdata/be : registered bus command
//   mem_ready           : bus accepts the command this cycle
//   mem_rvalid/mem_rdata: bus response
// Optional: MEM_PORT_ARBITER_PERF_EN adds if_wait_cnt/ls_wait_cnt, saturating
// counts of cycles each requester spent waiting for a grant.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned LS_STREAK_MAX = LS_STREAK_MAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
`ifdef MEM_PORT_ARBITER_PERF_EN
  output logic [31:0]     if_wait_cnt,
  output logic [31:0]     ls_wait_cnt,
`endif
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [3:0]      ls_be,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned STREAK_W = $clog2(LS_STREAK_MAX + 1);

  arb_state_t      state_q, state_d;
  logic            drop_q, drop_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]      mem_be_q, mem_be_d;

  logic [STREAK_W-1:0] streak;
  logic                streak_at_max;
  logic                arb_point;
  arb_owner_t          pick;
  logic                pick_valid;

  // Arbitration decision, used in IDLE and at the end of each WAIT state.
  assign streak_at_max = (streak == STREAK_W'(LS_STREAK_MAX));
  assign pick          = pick_owner(ls_req, if_req, streak_at_max);
  assign pick_valid    = (pick == OWN_LS) || (if_req && !if_flush);

  // Handshake pulses decoded from the current state.
  assign if_gnt    = (state_q == ST_REQ_IF) && mem_ready;
  assign ls_gnt    = (state_q == ST_REQ_LS) && mem_ready;
  // A flush in the response cycle also kills the response.
  assign if_rvalid = (state_q == ST_WAIT_IF) && mem_rvalid && !drop_q && !if_flush;
  assign ls_rvalid = (state_q == ST_WAIT_LS) && mem_rvalid;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  // Grant FSM next-state and bus command load.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    arb_point   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        arb_point = 1'b1;
      end
      ST_REQ_IF: begin
        if (mem_ready) begin
          // Accepted command cannot be recalled; remember to drop its data.
          state_d = ST_WAIT_IF;
          if (if_flush) begin
            drop_d = 1'b1;
          end
        end else if (if_flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ_LS: begin
        if (mem_ready) begin
          state_d = ST_WAIT_LS;
        end
      end
      ST_WAIT_IF: begin
        if (if_flush) begin
          drop_d = 1'b1;
        end
        if (mem_rvalid) begin
          drop_d    = 1'b0;
          arb_point = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_WAIT_LS: begin
        if (mem_rvalid) begin
          arb_point = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (arb_point && pick_valid) begin
      if (pick == OWN_LS) begin
        state_d     = ST_REQ_LS;
        mem_we_d    = ls_we;
        mem_addr_d  = ls_addr;
        mem_wdata_d = ls_wdata;
        mem_be_d    = ls_be;
      end else begin
        state_d     = ST_REQ_IF;
        mem_we_d    = 1'b0;
        mem_addr_d  = if_addr;
        mem_wdata_d = '0;
        mem_be_d    = 4'hF;
      end
    end

    mem_req_d = (state_d == ST_REQ_IF) || (state_d == ST_REQ_LS);
  end

  // State and bus command registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  // Consecutive LS grants while a fetch waits.
  sat_counter #(
    .W   (STREAK_W),
    .MAX (STREAK_W'(LS_STREAK_MAX))
  ) u_streak (
    .clk (clk),
    .rst (rst),
    .inc (ls_gnt && if_req),
    .clr (if_gnt || (arb_point && !if_req)),
    .cnt (streak)
  );

`ifdef MEM_PORT_ARBITER_PERF_EN
  // Cycles spent with a request raised but not yet granted.
  sat_counter #(
    .W   (32),
    .MAX ('1)
  ) u_if_wait (
    .clk (clk),
    .rst (rst),
    .inc (if_req && !if_gnt),
    .clr (1'b0),
    .cnt (if_wait_cnt)
  );

  sat_counter #(
    .W   (32),
    .MAX ('1)
  ) u_ls_wait (
    .clk (clk),
    .rst (rst),
    .inc (ls_req && !ls_gnt),
    .clr (1'b0),
    .cnt (ls_wait_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Inputs change 1ns after the
// rising edge; outputs are sampled on the falling edge. Expected responses
// are queued when the bench drives mem_rvalid and popped when checked.
module tb_mem_port_arbiter;
  import arb_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req, if_flush, ls_req, ls_we, mem_ready, mem_rvalid;
  logic [XLEN-1:0] if_addr, ls_addr, ls_wdata, mem_rdata;
  logic [3:0]      ls_be;
  logic            if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_req, mem_we;
  logic [XLEN-1:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]      mem_be;
`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0]     if_wait_cnt, ls_wait_cnt;
`endif

  typedef struct {
    logic            is_ls;
    logic            chk_data;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .LS_STREAK_MAX(4)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef MEM_PORT_ARBITER_PERF_EN
    .if_wait_cnt(if_wait_cnt),
    .ls_wait_cnt(ls_wait_cnt),
`endif
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_be      (ls_be),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    cyc(); cyc();
    smp();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_gnt, if_rvalid, if_rdata,
         ls_gnt, ls_rvalid, ls_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h be=%h, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_be);
    end
    checks++;
    if (dut.state_q !== ST_IDLE || dut.streak !== '0 || dut.drop_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: state=%0d streak=%0d drop=%b, want 0 0 0",
               dut.state_q, dut.streak, dut.drop_q);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h100; mem_ready = 1'b1;
    smp();
    checks++;
    if (mem_req !== 1'b0 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle: mem_req=%b if_gnt=%b, want 0 0", mem_req, if_gnt);
    end
    cyc();
    smp();
    checks++;
    if ({mem_req, if_gnt, mem_we, mem_be, mem_addr} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h100}) begin
      errors++;
      $display("FAIL fetch_cmd: req=%b gnt=%b we=%b be=%h addr=%h, want 1 1 0 f 00000100",
               mem_req, if_gnt, mem_we, mem_be, mem_addr);
    end
    cyc();
    if_req = 1'b0;
    smp();
    checks++;
    if (if_rvalid !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait: if_rvalid=%b mem_req=%b, want 0 0", if_rvalid, mem_req);
    end
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
    sb_q.push_back('{is_ls: 1'b0, chk_data: 1'b1, data: 32'h00500093});
    smp();
    checks++;
    if (if_rvalid !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL fetch_rvalid: if_rvalid=%b pending=%0d, want 1", if_rvalid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (if_rdata !== e.data) begin
        errors++;
        $display("FAIL fetch_rdata: got %h want %h", if_rdata, e.data);
      end
    end
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0;
    smp();
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL fetch_idle_after: state=%0d want %0d", dut.state_q, ST_IDLE);
    end
    cyc();
  endtask

  task automatic test_contention();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000; ls_be = 4'hF; mem_ready = 1'b1;
    smp();
    cyc();
    smp();
    checks++;
    if ({ls_gnt, if_gnt, mem_addr} !== {1'b1, 1'b0, 32'h2000}) begin
      errors++;
      $display("FAIL cont_ls_first: ls_gnt=%b if_gnt=%b addr=%h, want 1 0 00002000",
               ls_gnt, if_gnt, mem_addr);
    end
    cyc();
    ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    sb_q.push_back('{is_ls: 1'b1, chk_data: 1'b1, data: 32'h11223344});
    smp();
    checks++;
    if (ls_rvalid !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL cont_ls_rvalid: ls_rvalid=%b pending=%0d, want 1", ls_rvalid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (ls_rdata !== e.data || dut.streak !== 3'd1) begin
        errors++;
        $display("FAIL cont_ls_rdata: rdata=%h streak=%0d, want %h 1", ls_rdata, dut.streak, e.data);
      end
    end
    cyc();
    mem_rvalid = 1'b0;
    smp();
    checks++;
    if ({mem_req, if_gnt, mem_addr} !== {1'b1, 1'b1, 32'h104}) begin
      errors++;
      $display("FAIL cont_if_next: req=%b if_gnt=%b addr=%h, want 1 1 00000104",
               mem_req, if_gnt, mem_addr);
    end
    cyc();
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
    sb_q.push_back('{is_ls: 1'b0, chk_data: 1'b1, data: 32'h00000013});
    smp();
    checks++;
    if (if_rvalid !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL cont_if_rvalid: if_rvalid=%b pending=%0d, want 1", if_rvalid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (if_rdata !== e.data || dut.streak !== '0) begin
        errors++;
        $display("FAIL cont_if_rdata: rdata=%h streak=%0d, want %h 0", if_rdata, dut.streak, e.data);
      end
    end
    cyc();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_starvation();
    exp_t e;
    int   n_ls = 0;
    int   n_ls_at_if = -1;
    logic seen_if = 1'b0;
    logic resp;
    logic own_ls;
    if_req = 1'b1; if_addr = 32'h200;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h3000; ls_wdata = 32'hCAFE0001; ls_be = 4'b0011;
    mem_ready = 1'b1;
    for (int c = 0; c < 40 && !seen_if; c++) begin
      smp();
      if (mem_rvalid) begin
        checks++;
        if (sb_q.size() == 0 || ls_rvalid !== 1'b1 || if_rvalid !== 1'b0) begin
          errors++;
          $display("FAIL starve_store_ack: ls_rvalid=%b if_rvalid=%b pending=%0d, want 1 0",
                   ls_rvalid, if_rvalid, sb_q.size());
        end else begin
          e = sb_q.pop_front();
        end
      end
      if (ls_gnt) begin
        n_ls++;
        if (n_ls == 1) begin
          checks++;
          if ({mem_we, mem_wdata, mem_be, mem_addr} !== {1'b1, 32'hCAFE0001, 4'b0011, 32'h3000}) begin
            errors++;
            $display("FAIL starve_store_cmd: we=%b wdata=%h be=%h addr=%h, want 1 cafe0001 3 00003000",
                     mem_we, mem_wdata, mem_be, mem_addr);
          end
        end
      end
      if (if_gnt) begin
        seen_if = 1'b1;
        n_ls_at_if = n_ls;
      end
      resp = ls_gnt | if_gnt;
      own_ls = ls_gnt;
      cyc();
      mem_rvalid = resp;
      mem_rdata = $urandom();
      if (resp && own_ls) begin
        sb_q.push_back('{is_ls: 1'b1, chk_data: 1'b0, data: mem_rdata});
      end
      if (resp && !own_ls) begin
        if_req = 1'b0; ls_req = 1'b0;
        sb_q.push_back('{is_ls: 1'b0, chk_data: 1'b1, data: mem_rdata});
      end
    end
    checks++;
    if (!seen_if || n_ls_at_if != 4) begin
      errors++;
      $display("FAIL starve_bound: if_gnt_seen=%b ls_gnts_before=%0d, want 1 4", seen_if, n_ls_at_if);
    end
    smp();
    checks++;
    if (if_rvalid !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL starve_if_rvalid: if_rvalid=%b pending=%0d, want 1", if_rvalid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (if_rdata !== e.data || dut.streak !== '0) begin
        errors++;
        $display("FAIL starve_if_done: rdata=%h streak=%0d, want %h 0", if_rdata, dut.streak, e.data);
      end
    end
    cyc();
    mem_rvalid = 1'b0; ls_we = 1'b0; ls_wdata = '0;
  endtask

  task automatic test_flush_wait();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h300; mem_ready = 1'b1;
    smp();
    cyc();
    smp();
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL fw_gnt: if_gnt=%b want 1", if_gnt);
    end
    cyc();
    if_req = 1'b0; if_flush = 1'b1;
    smp();
    cyc();
    if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    smp();
    checks++;
    if ({if_rvalid, if_rdata} !== '0) begin
      errors++;
      $display("FAIL fw_drop: if_rvalid=%b if_rdata=%h, want 0 00000000", if_rvalid, if_rdata);
    end
    cyc();
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h304;
    smp();
    checks++;
    if (dut.drop_q !== 1'b0 || dut.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL fw_clear: drop=%b state=%0d, want 0 %0d", dut.drop_q, dut.state_q, ST_IDLE);
    end
    cyc();
    smp();
    checks++;
    if ({if_gnt, mem_addr} !== {1'b1, 32'h304}) begin
      errors++;
      $display("FAIL fw_refetch_gnt: if_gnt=%b addr=%h, want 1 00000304", if_gnt, mem_addr);
    end
    cyc();
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00A00113;
    sb_q.push_back('{is_ls: 1'b0, chk_data: 1'b1, data: 32'h00A00113});
    smp();
    checks++;
    if (if_rvalid !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL fw_refetch_rvalid: if_rvalid=%b pending=%0d, want 1", if_rvalid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (if_rdata !== e.data) begin
        errors++;
        $display("FAIL fw_refetch_rdata: got %h want %h", if_rdata, e.data);
      end
    end
    cyc();
    mem_rvalid = 1'b0;
  endtask

  task automatic test_flush_req();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h400; mem_ready = 1'b0;
    smp();
    cyc();
    if_flush = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h5000; ls_be = 4'hF;
    smp();
    checks++;
    if (mem_req !== 1'b1 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fr_req: mem_req=%b if_gnt=%b, want 1 0", mem_req, if_gnt);
    end
    cyc();
    if_flush = 1'b0; if_req = 1'b0;
    smp();
    checks++;
    if ({mem_req, if_gnt, ls_gnt} !== 3'b000) begin
      errors++;
      $display("FAIL fr_retract: mem_req=%b if_gnt=%b ls_gnt=%b, want 0 0 0", mem_req, if_gnt, ls_gnt);
    end
    cyc();
    mem_ready = 1'b1;
    smp();
    checks++;
    if ({ls_gnt, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h5000}) begin
      errors++;
      $display("FAIL fr_ls_gnt: ls_gnt=%b we=%b addr=%h, want 1 0 00005000", ls_gnt, mem_we, mem_addr);
    end
    cyc();
    ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55667788;
    sb_q.push_back('{is_ls: 1'b1, chk_data: 1'b1, data: 32'h55667788});
    smp();
    checks++;
    if (ls_rvalid !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL fr_ls_rvalid: ls_rvalid=%b pending=%0d, want 1", ls_rvalid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (ls_rdata !== e.data) begin
        errors++;
        $display("FAIL fr_ls_rdata: got %h want %h", ls_rdata, e.data);
      end
    end
    cyc();
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h440;
    smp();
    cyc();
    if_flush = 1'b1;
    smp();
    checks++;
    if (if_gnt !== 1'b1) begin
      errors++;
      $display("FAIL fr_coincide_gnt: if_gnt=%b want 1", if_gnt);
    end
    cyc();
    if_flush = 1'b0; if_req = 1'b0;
    smp();
    checks++;
    if (dut.drop_q !== 1'b1 || dut.state_q !== ST_WAIT_IF) begin
      errors++;
      $display("FAIL fr_coincide_drop: drop=%b state=%0d, want 1 %0d", dut.drop_q, dut.state_q, ST_WAIT_IF);
    end
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    smp();
    checks++;
    if ({if_rvalid, if_rdata} !== '0) begin
      errors++;
      $display("FAIL fr_coincide_rvalid: if_rvalid=%b if_rdata=%h, want 0 00000000", if_rvalid, if_rdata);
    end
    cyc();
    mem_rvalid = 1'b0;
    smp();
    checks++;
    if (dut.state_q !== ST_IDLE || dut.drop_q !== 1'b0) begin
      errors++;
      $display("FAIL fr_coincide_idle: state=%0d drop=%b, want %0d 0", dut.state_q, dut.drop_q, ST_IDLE);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    if_req = 1'b1; if_addr = 32'h600;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h6000; ls_be = 4'hF; mem_ready = 1'b1;
    smp();
    cyc();
    smp();
    checks++;
    if (ls_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rm_ls_gnt: ls_gnt=%b if_gnt=%b, want 1 0", ls_gnt, if_gnt);
    end
    cyc();
    ls_req = 1'b0; if_req = 1'b0; rst = 1'b1;
    smp();
    checks++;
    if (dut.state_q !== ST_WAIT_LS || dut.streak !== 3'd1) begin
      errors++;
      $display("FAIL rm_pre: state=%0d streak=%0d, want %0d 1", dut.state_q, dut.streak, ST_WAIT_LS);
    end
    cyc();
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    smp();
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_gnt, if_rvalid, if_rdata,
         ls_gnt, ls_rvalid, ls_rdata} !== '0) begin
      errors++;
      $display("FAIL rm_outputs: ls_rvalid=%b ls_rdata=%h req=%b addr=%h be=%h, want all 0",
               ls_rvalid, ls_rdata, mem_req, mem_addr, mem_be);
    end
    checks++;
    if (dut.state_q !== ST_IDLE || dut.streak !== '0) begin
      errors++;
      $display("FAIL rm_state: state=%0d streak=%0d, want %0d 0", dut.state_q, dut.streak, ST_IDLE);
    end
    cyc();
    mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h700;
    smp();
    cyc();
    smp();
    checks++;
    if ({if_gnt, mem_addr} !== {1'b1, 32'h700}) begin
      errors++;
      $display("FAIL rm_fetch_gnt: if_gnt=%b addr=%h, want 1 00000700", if_gnt, mem_addr);
    end
    cyc();
    if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000513;
    sb_q.push_back('{is_ls: 1'b0, chk_data: 1'b1, data: 32'h00000513});
    smp();
    checks++;
    if (if_rvalid !== 1'b1 || sb_q.size() == 0) begin
      errors++;
      $display("FAIL rm_fetch_rvalid: if_rvalid=%b pending=%0d, want 1", if_rvalid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      checks++;
      if (if_rdata !== e.data) begin
        errors++;
        $display("FAIL rm_fetch_rdata: got %h want %h", if_rdata, e.data);
      end
    end
    cyc();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_flush_wait();
    test_flush_req();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses never seen, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
